seq_ctrl_unit: RTL and testbench

Parametrised multi-cycle sequencer for the Y86-64 sequential core. It generalises the fixed six-state FETCH..UPDATE_PC loop into a handshake-driven controller with the following behaviour:
- stalls on variable memory latency;
- skips the MEMORY and WRITE_BACK stages when an instruction does not need them;
- detects memory timeouts;
- tracks Y86 status and enters a HALT state.

It sits between the fetch/decode/execute datapath and the ram, and it owns the PC register.

---
 rtl/seq_ctrl_if.sv | 44 ++++
 rtl/seq_ctrl_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_seq_ctrl_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_ctrl_if.sv
// Handshake/bus bundle between the Y86-64 sequencer and its datapath/ram.
// The master modport is the sequencer; the slave modport is the datapath/ram side.
interface seq_ctrl_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned CNT_W  = 32
) ();
    logic [3:0]        icode_i;
    logic              instr_valid_i;
    logic              imem_error_i;
    logic              dmem_error_i;
    logic              cnd_i;
    logic [ADDR_W-1:0] valP_i;
    logic [ADDR_W-1:0] valC_i;
    logic [ADDR_W-1:0] valM_i;
    logic              mem_ack_i;
    logic              step_hold_i;

    logic [ADDR_W-1:0] pc_o;
    logic [2:0]        state_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic              mem_instr_o;
    logic              ir_load_o;
    logic              cc_we_o;
    logic              reg_we_o;
    logic [2:0]        stat_o;
    logic              halted_o;
    logic [CNT_W-1:0]  cycle_cnt_o;
    logic [CNT_W-1:0]  instret_o;

    modport master (
        input  icode_i, instr_valid_i, imem_error_i, dmem_error_i, cnd_i,
        input  valP_i, valC_i, valM_i, mem_ack_i, step_hold_i,
        output pc_o, state_o, mem_req_o, mem_we_o, mem_instr_o, ir_load_o,
        output cc_we_o, reg_we_o, stat_o, halted_o, cycle_cnt_o, instret_o
    );

    modport slave (
        output icode_i, instr_valid_i, imem_error_i, dmem_error_i, cnd_i,
        output valP_i, valC_i, valM_i, mem_ack_i, step_hold_i,
        input  pc_o, state_o, mem_req_o, mem_we_o, mem_instr_o, ir_load_o,
        input  cc_we_o, reg_we_o, stat_o, halted_o, cycle_cnt_o, instret_o
    );
endinterface

// File: rtl/seq_ctrl_unit.sv
// Multi-cycle FETCH..UPDATE_PC sequencer for the Y86-64 core; owns the PC and Y86 status.
// Define PERF_CNT_EN to build the cycle and retired-instruction counters.
module seq_ctrl_unit #(
    parameter int unsigned       ADDR_W      = 64,
    parameter logic [ADDR_W-1:0] PC_RESET    = {ADDR_W{1'b0}},
    parameter int unsigned       MEM_TIMEOUT = 15,
    parameter int unsigned       CNT_W       = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    seq_ctrl_if.master bus
);
    localparam logic [2:0] S_FETCH      = 3'd0;
    localparam logic [2:0] S_DECODE     = 3'd1;
    localparam logic [2:0] S_EXECUTE    = 3'd2;
    localparam logic [2:0] S_MEMORY     = 3'd3;
    localparam logic [2:0] S_WRITE_BACK = 3'd4;
    localparam logic [2:0] S_UPDATE_PC  = 3'd5;
    localparam logic [2:0] S_HALT       = 3'd6;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam int unsigned    TMO_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    // Instructions that need the MEMORY stage: rmmovq, mrmovq, call, ret, pushq, popq.
    function automatic logic icode_uses_mem(input logic [3:0] ic);
        case (ic)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: icode_uses_mem = 1'b1;
            default:                            icode_uses_mem = 1'b0;
        endcase
    endfunction

    function automatic logic icode_mem_write(input logic [3:0] ic);
        case (ic)
            4'h4, 4'h8, 4'hA: icode_mem_write = 1'b1;
            default:          icode_mem_write = 1'b0;
        endcase
    endfunction

    function automatic logic icode_alu_wb(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h3, 4'h6: icode_alu_wb = 1'b1;
            default:          icode_alu_wb = 1'b0;
        endcase
    endfunction

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        stat_q, stat_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] next_pc_s;
    logic              tmo_hit_s;

    // PC target chosen when leaving UPDATE_PC.
    always_comb begin
        next_pc_s = bus.valP_i;
        if ((bus.icode_i == 4'h8) || ((bus.icode_i == 4'h7) && bus.cnd_i)) begin
            next_pc_s = bus.valC_i;
        end else if (bus.icode_i == 4'h9) begin
            next_pc_s = bus.valM_i;
        end else begin
            next_pc_s = bus.valP_i;
        end
    end

    assign tmo_hit_s = (tmo_q == TMO_LAST);

    // Next-state, PC, status and timeout-counter logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stat_d  = stat_q;
        tmo_d   = {TMO_W{1'b0}};
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ack_i) begin
                    if (bus.imem_error_i) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = S_DECODE;
                    end
                end else if (tmo_hit_s) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DECODE: begin
                if (!bus.instr_valid_i) begin
                    state_d = S_HALT;
                    stat_d  = STAT_INS;
                end else if (bus.icode_i == 4'h0) begin
                    state_d = S_HALT;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (icode_uses_mem(bus.icode_i)) begin
                    state_d = S_MEMORY;
                end else if (icode_alu_wb(bus.icode_i)) begin
                    state_d = S_WRITE_BACK;
                end else begin
                    state_d = S_UPDATE_PC;
                end
            end
            S_MEMORY: begin
                if (bus.mem_ack_i) begin
                    if (bus.dmem_error_i) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else if (bus.icode_i == 4'h4) begin
                        state_d = S_UPDATE_PC;
                    end else begin
                        state_d = S_WRITE_BACK;
                    end
                end else if (tmo_hit_s) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WRITE_BACK: begin
                state_d = S_UPDATE_PC;
            end
            S_UPDATE_PC: begin
                if (bus.step_hold_i) begin
                    state_d = S_UPDATE_PC;
                end else begin
                    pc_d    = next_pc_s;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
                stat_d  = STAT_ADR;
            end
        endcase
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            stat_q  <= STAT_AOK;
            tmo_q   <= {TMO_W{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stat_q  <= stat_d;
            tmo_q   <= tmo_d;
        end
    end

    logic mem_req_s, mem_we_s, mem_instr_s, ir_load_s, cc_we_s, reg_we_s;

    // Request and pulse decode; ir_load follows the fetch ack in the same cycle.
    always_comb begin
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_instr_s = 1'b0;
        ir_load_s   = 1'b0;
        cc_we_s     = 1'b0;
        reg_we_s    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s   = 1'b1;
                mem_instr_s = 1'b1;
                ir_load_s   = bus.mem_ack_i & ~bus.imem_error_i;
            end
            S_EXECUTE: begin
                cc_we_s = (bus.icode_i == 4'h6);
            end
            S_MEMORY: begin
                mem_req_s = 1'b1;
                mem_we_s  = icode_mem_write(bus.icode_i);
            end
            S_WRITE_BACK: begin
                reg_we_s = 1'b1;
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    assign bus.pc_o        = pc_q;
    assign bus.state_o     = state_q;
    assign bus.stat_o      = stat_q;
    assign bus.halted_o    = (state_q == S_HALT);
    assign bus.mem_req_o   = mem_req_s;
    assign bus.mem_we_o    = mem_we_s;
    assign bus.mem_instr_o = mem_instr_s;
    assign bus.ir_load_o   = ir_load_s;
    assign bus.cc_we_o     = cc_we_s;
    assign bus.reg_we_o    = reg_we_s;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    // Counter increments; both wrap naturally at 2^CNT_W.
    always_comb begin
        if (state_q != S_HALT) begin
            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end else begin
            cyc_cnt_d = cyc_cnt_q;
        end
        if ((state_q == S_UPDATE_PC) && (state_d == S_FETCH)) begin
            instret_d = instret_q + CNT_W'(1);
        end else begin
            instret_d = instret_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_cnt_q <= {CNT_W{1'b0}};
            instret_q <= {CNT_W{1'b0}};
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            instret_q <= instret_d;
        end
    end

    assign bus.cycle_cnt_o = cyc_cnt_q;
    assign bus.instret_o   = instret_q;
`else
    assign bus.cycle_cnt_o = {CNT_W{1'b0}};
    assign bus.instret_o   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_ctrl_unit.sv
// Self-checking bench for seq_ctrl_unit: directed cases plus randomized instructions
// scored against a transaction-level model of per-instruction cycles, pulses, PC and status.
module tb_seq_ctrl_unit;
    localparam int unsigned AW     = 64;
    localparam int unsigned CW     = 32;
    localparam int          TMO    = 15;
    localparam logic [63:0] PC_RST = 64'h0;

    logic clk_i = 1'b0;
    logic rst_i;

    seq_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

    seq_ctrl_unit #(
        .ADDR_W(AW), .PC_RESET(PC_RST), .MEM_TIMEOUT(TMO), .CNT_W(CW)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    int          total_cnt = 0;
    int          bad_cnt   = 0;
    logic [63:0] m_pc;
    logic [2:0]  m_stat;
    logic        m_halted;
    logic [31:0] m_cyc;
    logic [31:0] m_ret;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_cnt(input logic [31:0] v);
`ifdef PERF_CNT_EN
        return {32'h0, v};
`else
        return 64'(v & 32'h0);
`endif
    endfunction

    // Transaction-level model: what one instruction costs and leaves behind.
    task automatic model_instr(
        input logic [3:0] ic, input logic vld, input logic ie, input logic de, input logic cnd,
        input logic [63:0] vp, input logic [63:0] vc, input logic [63:0] vm,
        input int fw, input int mw, input int hd,
        output int e_cyc, output int e_req, output int e_instr, output int e_ir,
        output int e_cc, output int e_we, output int e_reg,
        output logic [63:0] e_pc, output logic [2:0] e_stat, output logic e_halt);
        bit is_mem;
        bit is_wr;
        bit wb;
        is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        is_wr  = ic inside {4'h4, 4'h8, 4'hA};
        e_cyc = 0; e_req = 0; e_instr = 0; e_ir = 0; e_cc = 0; e_we = 0; e_reg = 0;
        e_pc = m_pc; e_stat = m_stat; e_halt = 1'b1;
        if (fw >= TMO) begin
            e_cyc = TMO; e_req = TMO; e_instr = TMO; e_stat = 3'd3;
            return;
        end
        e_cyc = fw + 1; e_req = fw + 1; e_instr = fw + 1;
        if (ie) begin e_stat = 3'd3; return; end
        e_ir = 1;
        e_cyc++;
        if (!vld) begin e_stat = 3'd4; return; end
        if (ic == 4'h0) begin e_stat = 3'd2; return; end
        e_cyc++;
        e_cc = (ic == 4'h6) ? 1 : 0;
        if (is_mem) begin
            if (mw >= TMO) begin
                e_cyc += TMO; e_req += TMO; e_we = is_wr ? TMO : 0; e_stat = 3'd3;
                return;
            end
            e_cyc += mw + 1; e_req += mw + 1; e_we = is_wr ? mw + 1 : 0;
            if (de) begin e_stat = 3'd3; return; end
            wb = (ic != 4'h4);
        end else begin
            wb = ic inside {4'h2, 4'h3, 4'h6};
        end
        if (wb) begin e_cyc++; e_reg = 1; end
        e_cyc += 1 + hd;
        e_halt = 1'b0;
        if (ic == 4'h8 || (ic == 4'h7 && cnd)) e_pc = vc;
        else if (ic == 4'h9)                   e_pc = vm;
        else                                   e_pc = vp;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bus.mem_ack_i = 1'b0;
        bus.step_hold_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        m_pc = PC_RST; m_stat = 3'd1; m_halted = 1'b0; m_cyc = 32'd0; m_ret = 32'd0;
        check_val("rst_state", 64'(bus.state_o), 64'd0);
        check_val("rst_pc", bus.pc_o, PC_RST);
        check_val("rst_stat", 64'(bus.stat_o), 64'd1);
        check_val("rst_halted", 64'(bus.halted_o), 64'd0);
        check_val("rst_req", 64'(bus.mem_req_o), 64'd1);
        check_val("rst_instr", 64'(bus.mem_instr_o), 64'd1);
        check_val("rst_cyc", 64'(bus.cycle_cnt_o), exp_cnt(m_cyc));
        check_val("rst_ret", 64'(bus.instret_o), exp_cnt(m_ret));
    endtask

    // Acts as ram/datapath for one instruction starting in FETCH, then scores it.
    task automatic run_instr(
        input logic [3:0] ic, input logic vld, input logic ie, input logic de, input logic cnd,
        input logic [63:0] vp, input logic [63:0] vc, input logic [63:0] vm,
        input int fw, input int mw, input int hd);
        int e_cyc, e_req, e_instr, e_ir, e_cc, e_we, e_reg;
        logic [63:0] e_pc;
        logic [2:0]  e_stat, st;
        logic        e_halt;
        int cyc, f_cnt, m_cnt, h_cnt, n_req, n_instr, n_ir, n_cc, n_we, n_reg;
        bit done, pc_still;
        logic [63:0] pc0;
        model_instr(ic, vld, ie, de, cnd, vp, vc, vm, fw, mw, hd,
                    e_cyc, e_req, e_instr, e_ir, e_cc, e_we, e_reg, e_pc, e_stat, e_halt);
        cyc = 0; f_cnt = 0; m_cnt = 0; h_cnt = 0; n_req = 0; n_instr = 0;
        n_ir = 0; n_cc = 0; n_we = 0; n_reg = 0; done = 1'b0; pc_still = 1'b1;
        pc0 = bus.pc_o;
        bus.icode_i = ic; bus.instr_valid_i = vld; bus.imem_error_i = ie;
        bus.dmem_error_i = de; bus.cnd_i = cnd;
        bus.valP_i = vp; bus.valC_i = vc; bus.valM_i = vm;
        while (!done && cyc < 300) begin
            st = bus.state_o;
            bus.mem_ack_i = 1'b0;
            bus.step_hold_i = 1'b0;
            if (bus.mem_req_o) begin
                if (bus.mem_instr_o) begin bus.mem_ack_i = (f_cnt == fw); f_cnt++; end
                else begin bus.mem_ack_i = (m_cnt == mw); m_cnt++; end
            end
            if (st == 3'd5) begin bus.step_hold_i = (h_cnt < hd); h_cnt++; end
            @(negedge clk_i);
            n_req   += int'(bus.mem_req_o);
            n_instr += int'(bus.mem_instr_o);
            n_ir    += int'(bus.ir_load_o);
            n_cc    += int'(bus.cc_we_o);
            n_we    += int'(bus.mem_we_o & bus.mem_req_o);
            n_reg   += int'(bus.reg_we_o);
            if (bus.pc_o !== pc0) pc_still = 1'b0;
            @(posedge clk_i); #1;
            cyc++;
            if (bus.state_o == 3'd6 || (bus.state_o == 3'd0 && st != 3'd0)) done = 1'b1;
        end
        bus.mem_ack_i = 1'b0;
        bus.step_hold_i = 1'b0;
        m_cyc = m_cyc + 32'(e_cyc);
        if (!e_halt) m_ret = m_ret + 32'd1;
        m_pc = e_pc; m_stat = e_stat; m_halted = e_halt;
        check_val("finished", 64'(done), 64'd1);
        check_val("cycles", 64'(cyc), 64'(e_cyc));
        check_val("end_state", 64'(bus.state_o), e_halt ? 64'd6 : 64'd0);
        check_val("pc", bus.pc_o, e_pc);
        check_val("stat", 64'(bus.stat_o), 64'(e_stat));
        check_val("halted", 64'(bus.halted_o), 64'(e_halt));
        check_val("req_cycles", 64'(n_req), 64'(e_req));
        check_val("instr_cycles", 64'(n_instr), 64'(e_instr));
        check_val("ir_load", 64'(n_ir), 64'(e_ir));
        check_val("cc_we", 64'(n_cc), 64'(e_cc));
        check_val("mem_we", 64'(n_we), 64'(e_we));
        check_val("reg_we", 64'(n_reg), 64'(e_reg));
        check_val("pc_stable", 64'(pc_still), 64'd1);
        check_val("cycle_cnt", 64'(bus.cycle_cnt_o), exp_cnt(m_cyc));
        check_val("instret", 64'(bus.instret_o), exp_cnt(m_ret));
    endtask

    task automatic check_halt_hold();
        for (int i = 0; i < 3; i++) begin
            bus.mem_ack_i = 1'b1;
            @(negedge clk_i);
            check_val("halt_req", 64'(bus.mem_req_o), 64'd0);
            check_val("halt_pulses", 64'({bus.ir_load_o, bus.cc_we_o, bus.reg_we_o, bus.mem_we_o}), 64'd0);
            check_val("halt_flag", 64'(bus.halted_o), 64'd1);
            check_val("halt_pc", bus.pc_o, m_pc);
            check_val("halt_stat", 64'(bus.stat_o), 64'(m_stat));
            @(posedge clk_i); #1;
        end
        bus.mem_ack_i = 1'b0;
        check_val("halt_cyc_frozen", 64'(bus.cycle_cnt_o), exp_cnt(m_cyc));
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0)      return 99;
        else if (r == 1) return TMO - 1;
        else if (r == 2) return TMO;
        else             return int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [3:0] ic;
        logic       vld;
        bus.icode_i = 4'h1; bus.instr_valid_i = 1'b1; bus.imem_error_i = 1'b0;
        bus.dmem_error_i = 1'b0; bus.cnd_i = 1'b0; bus.valP_i = 64'h0;
        bus.valC_i = 64'h0; bus.valM_i = 64'h0; bus.mem_ack_i = 1'b0; bus.step_hold_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        do_reset();

        run_instr(4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1, 64'h0, 64'h0, 0, 0, 0);
        run_instr(4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 64'hB, 64'h0, 64'h0, 0, 3, 0);
        run_instr(4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA, 64'h100, 64'h0, 0, 0, 0);
        run_instr(4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 64'hA, 64'h100, 64'h0, 0, 0, 0);
        run_instr(4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 64'h13, 64'h200, 64'h0, 1, 2, 0);
        run_instr(4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 64'h201, 64'h0, 64'h13, 0, 0, 0);
        run_instr(4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 64'h15, 64'h0, 64'h0, TMO - 1, 0, 2);
        run_instr(4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1F, 64'h0, 64'h0, 0, TMO - 1, 0);

        run_instr(4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1, 64'h0, 64'h0, 99, 0, 0);
        check_halt_hold();
        do_reset();
        run_instr(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 64'hA, 64'h0, 64'h0, 0, 0, 0);
        check_halt_hold();
        do_reset();
        run_instr(4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h20, 64'h0, 64'h0, 0, 0, 0);
        run_instr(4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h21, 64'h0, 64'h0, 0, 0, 0);
        check_halt_hold();
        do_reset();

        // Reset while a data read is outstanding.
        run_instr(4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h40, 64'h0, 64'h0, 0, 0, 0);
        bus.icode_i = 4'h5;
        for (int i = 0; i < 6; i++) begin
            bus.mem_ack_i = bus.mem_instr_o;
            @(posedge clk_i); #1;
        end
        bus.mem_ack_i = 1'b0;
        check_val("mid_mem_state", 64'(bus.state_o), 64'd3);
        check_val("mid_mem_req", 64'(bus.mem_req_o), 64'd1);
        do_reset();

        for (int n = 0; n < 80; n++) begin
            ic = 4'($urandom_range(0, 15));
            if (ic == 4'h0 && $urandom_range(0, 3) != 0) ic = 4'h1;
            vld = (ic <= 4'hB) ? ($urandom_range(0, 19) != 0) : 1'($urandom_range(0, 1));
            run_instr(ic, vld, ($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0),
                      1'($urandom_range(0, 1)),
                      {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                      pick_wait(), pick_wait(),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            if (m_halted) begin
                check_halt_hold();
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
